// File: rtl/usb_receiver.sv
// usb_receiver: USB full-speed serial receiver.
// Resynchronizes D+/D-, recovers bit timing from D+ transitions, decodes NRZI,
// strips stuffed bits, checks SYNC and PID, and pushes every payload byte
// (CRC bytes included) to the RX FIFO with a one-cycle strobe.
//
// Ports:
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   d_plus/d_minus USB line pair, asynchronous to clk
//   rx_full        RX FIFO full flag
//   rx_data        received byte, valid while store_rx is high
//   store_rx       one-cycle FIFO write strobe
//   rx_pid         PID nibble of the current/last valid packet
//   receiving      high from SYNC start until packet done or error
//   rx_packet_done one-cycle pulse on a clean EOP
//   rx_error       sticky error level, cleared when the next SYNC starts
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | bus idle, waiting for the first K of a SYNC
// S_SYNC  | collecting the 8 SYNC bits (first K already counted)
// S_PID   | collecting the PID byte
// S_DATA  | collecting payload bytes, SE0 on a byte boundary starts EOP
// S_EOP   | expecting a second SE0 followed by J
// S_ERROR | bad packet, waiting for SE0 then J before returning to idle
module usb_receiver #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       rx_full,
  output logic [7:0] rx_data,
  output logic       store_rx,
  output logic [3:0] rx_pid,
  output logic       receiving,
  output logic       rx_packet_done,
  output logic       rx_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP, S_ERROR
  } state_t;

  // synchronizers; the third stage doubles as the edge-detect reference
  logic dp_meta_q, dp_sync_q, dp_dly_q;
  logic dm_meta_q, dm_sync_q, dm_dly_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_samp_q, prev_samp_d;
  state_t        state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    ones_q, ones_d;
  logic          eop_two_q, eop_two_d;
  logic          seen_se0_q, seen_se0_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          store_q, store_d;
  logic [3:0]    rx_pid_q, rx_pid_d;
  logic          receiving_q, receiving_d;
  logic          done_q, done_d;
  logic          rx_error_q, rx_error_d;

  logic       dp_edge, strobe;
  logic       line_j, line_k, line_se0, line_se1;
  logic       bit_val, to_error;
  logic [7:0] byte_w;

  assign dp_edge  = dp_sync_q ^ dp_dly_q;
  assign strobe   = (cnt_q == CW'(CLKS_PER_BIT / 2));
  assign line_j   =  dp_dly_q & ~dm_dly_q;
  assign line_k   = ~dp_dly_q &  dm_dly_q;
  assign line_se0 = ~dp_dly_q & ~dm_dly_q;
  assign line_se1 =  dp_dly_q &  dm_dly_q;
  assign bit_val  = (dp_dly_q == prev_samp_q);

  always_comb begin
    if (dp_edge || cnt_q == CW'(CLKS_PER_BIT - 1)) cnt_d = '0;
    else                                          cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    eop_two_d   = eop_two_q;
    seen_se0_d  = seen_se0_q;
    rx_data_d   = rx_data_q;
    rx_pid_d    = rx_pid_q;
    receiving_d = receiving_q;
    rx_error_d  = rx_error_q;
    store_d     = 1'b0;
    done_d      = 1'b0;
    to_error    = 1'b0;
    byte_w      = {bit_val, sh_q[7:1]};
    prev_samp_d = strobe ? dp_dly_q : prev_samp_q;

    if (strobe) begin
      unique case (state_q)
        S_IDLE: begin
          if (line_k) begin
            // the first K decodes to SYNC bit 0 (a zero)
            state_d     = S_SYNC;
            sh_d        = 8'h00;
            bit_cnt_d   = 3'd1;
            ones_d      = 3'd0;
            rx_error_d  = 1'b0;
            receiving_d = 1'b1;
          end
        end
        S_SYNC, S_PID, S_DATA: begin
          if (line_se1) begin
            to_error = 1'b1;
          end else if (line_se0) begin
            if (state_q == S_DATA && bit_cnt_q == 3'd0) begin
              state_d   = S_EOP;
              eop_two_d = 1'b0;
            end else begin
              to_error = 1'b1;
            end
          end else if (ones_q == 3'd6) begin
            // stuffed bit slot: a zero is dropped, a one is illegal
            ones_d = 3'd0;
            if (bit_val) to_error = 1'b1;
          end else begin
            ones_d    = bit_val ? ones_q + 3'd1 : 3'd0;
            sh_d      = byte_w;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              unique case (state_q)
                S_SYNC: begin
                  if (byte_w == 8'h80) state_d = S_PID;
                  else                 to_error = 1'b1;
                end
                S_PID: begin
                  if (byte_w[7:4] == ~byte_w[3:0]) begin
                    rx_pid_d = byte_w[3:0];
                    state_d  = S_DATA;
                  end else begin
                    to_error = 1'b1;
                  end
                end
                default: begin
                  if (rx_full) begin
                    to_error = 1'b1;
                  end else begin
                    rx_data_d = byte_w;
                    store_d   = 1'b1;
                  end
                end
              endcase
            end
          end
        end
        S_EOP: begin
          if (line_se0 && !eop_two_q) begin
            eop_two_d = 1'b1;
          end else if (line_j && eop_two_q) begin
            done_d      = 1'b1;
            receiving_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            to_error = 1'b1;
          end
        end
        S_ERROR: begin
          if (line_se0)                 seen_se0_d = 1'b1;
          else if (line_j && seen_se0_q) state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (to_error) begin
        state_d     = S_ERROR;
        receiving_d = 1'b0;
        rx_error_d  = 1'b1;
        // an SE0 that caused the error already counts as the end-of-packet SE0
        seen_se0_d  = line_se0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta_q   <= 1'b1;
      dp_sync_q   <= 1'b1;
      dp_dly_q    <= 1'b1;
      dm_meta_q   <= 1'b0;
      dm_sync_q   <= 1'b0;
      dm_dly_q    <= 1'b0;
      cnt_q       <= '0;
      prev_samp_q <= 1'b1;
      state_q     <= S_IDLE;
      sh_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      ones_q      <= 3'd0;
      eop_two_q   <= 1'b0;
      seen_se0_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      store_q     <= 1'b0;
      rx_pid_q    <= 4'h0;
      receiving_q <= 1'b0;
      done_q      <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      dp_meta_q   <= d_plus;
      dp_sync_q   <= dp_meta_q;
      dp_dly_q    <= dp_sync_q;
      dm_meta_q   <= d_minus;
      dm_sync_q   <= dm_meta_q;
      dm_dly_q    <= dm_sync_q;
      cnt_q       <= cnt_d;
      prev_samp_q <= prev_samp_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      eop_two_q   <= eop_two_d;
      seen_se0_q  <= seen_se0_d;
      rx_data_q   <= rx_data_d;
      store_q     <= store_d;
      rx_pid_q    <= rx_pid_d;
      receiving_q <= receiving_d;
      done_q      <= done_d;
      rx_error_q  <= rx_error_d;
    end
  end

  assign rx_data        = rx_data_q;
  assign store_rx       = store_q;
  assign rx_pid         = rx_pid_q;
  assign receiving      = receiving_q;
  assign rx_packet_done = done_q;
  assign rx_error       = rx_error_q;

endmodule
